// File: rtl/store_monitor_pkg.sv
// Shared types and constants for the store_monitor checker and its comparator sub-block.
package store_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISMATCH = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;

  // A one-entry table still needs a one-bit index port.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/store_monitor_match.sv
// Parallel (address, data) comparator over the expected table with a lowest-index priority encoder.
module store_monitor_match
  import store_monitor_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int IW    = idx_width(DEPTH)
) (
  input  logic [AW-1:0]    addr_tab [DEPTH],
  input  logic [DW-1:0]    data_tab [DEPTH],
  input  logic [DEPTH-1:0] avail,
  input  logic [AW-1:0]    dataadr,
  input  logic [DW-1:0]    writedata,
  output logic             hit_any,
  output logic [IW-1:0]    hit_idx
);

  logic [DEPTH-1:0] eq;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign eq[gi] = avail[gi] && (addr_tab[gi] == dataadr) && (data_tab[gi] == writedata);
    end
  endgenerate

  // Scanning downwards leaves the lowest matching index as the winner.
  always_comb begin
    hit_any = |eq;
    hit_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (eq[i]) hit_idx = IW'(i);
    end
  end

endmodule

// File: rtl/store_monitor.sv
// Store checker for the data-memory write port: compares each store to a loaded expected table.
// Optional RUN-state timeout enabled by defining STORE_MONITOR_TIMEOUT_EN.
module store_monitor
  import store_monitor_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int ORDERED     = 1,
  parameter int IGNORE_ADDR = 80,
  parameter int TIMEOUT     = 1000,
  localparam int IW         = idx_width(DEPTH),
  localparam int CW         = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [IW-1:0] load_idx,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  input  logic [CW-1:0] exp_count,
  input  logic          start,
  input  logic          memwrite,
  input  logic [AW-1:0] dataadr,
  input  logic [DW-1:0] writedata,
  output logic          pass,
  output logic          fail,
  output logic [1:0]    fail_code,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_data,
  output logic [CW-1:0] match_count,
  output logic [15:0]   ignored_count,
  output logic          busy
);

  localparam logic [AW-1:0] IGN_ADDR = AW'(IGNORE_ADDR);

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [CW-1:0]     match_count_reg, match_count_next;
  logic [15:0]       ignored_count_reg, ignored_count_next;
  logic [DEPTH-1:0]  hit_reg, hit_next;
  logic [1:0]        fail_code_reg, fail_code_next;
  logic [AW-1:0]     fail_addr_reg, fail_addr_next;
  logic [DW-1:0]     fail_data_reg, fail_data_next;
  logic [CW-1:0]     exp_clamped;
  logic [CW-1:0]     match_inc;

  logic [AW-1:0]     addr_tab [DEPTH];
  logic [DW-1:0]     data_tab [DEPTH];

  logic              match_any;
  logic [DEPTH-1:0]  match_mask;

`ifdef STORE_MONITOR_TIMEOUT_EN
  logic [31:0]       run_cnt_reg, run_cnt_next;
`else
  wire  [31:0]       unused_timeout = 32'(TIMEOUT);
`endif

  // Table is deliberately not reset; it is rewritten only while idle.
  always_ff @(posedge clk) begin
    if (state_reg == ST_IDLE && load_en) begin
      addr_tab[load_idx] <= load_addr;
      data_tab[load_idx] <= load_data;
    end
  end

  generate
    if (ORDERED != 0) begin : g_ord
      logic [IW-1:0] ord_idx;
      assign ord_idx    = match_count_reg[IW-1:0];
      assign match_any  = (addr_tab[ord_idx] == dataadr) && (data_tab[ord_idx] == writedata);
      assign match_mask = '0;
    end else begin : g_uno
      logic [DEPTH-1:0] valid;
      logic [IW-1:0]    hit_idx;
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
        assign valid[gi] = (CW'(gi) < cnt_reg);
      end
      store_monitor_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW),
        .IW    (IW)
      ) u_match (
        .addr_tab  (addr_tab),
        .data_tab  (data_tab),
        .avail     (valid & ~hit_reg),
        .dataadr   (dataadr),
        .writedata (writedata),
        .hit_any   (match_any),
        .hit_idx   (hit_idx)
      );
      assign match_mask = DEPTH'(1) << hit_idx;
    end
  endgenerate

  assign exp_clamped = (exp_count > CW'(DEPTH)) ? CW'(DEPTH) : exp_count;
  assign match_inc   = match_count_reg + CW'(1);

  always_comb begin
    state_next         = state_reg;
    cnt_next           = cnt_reg;
    match_count_next   = match_count_reg;
    ignored_count_next = ignored_count_reg;
    hit_next           = hit_reg;
    fail_code_next     = fail_code_reg;
    fail_addr_next     = fail_addr_reg;
    fail_data_next     = fail_data_reg;
`ifdef STORE_MONITOR_TIMEOUT_EN
    run_cnt_next       = run_cnt_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          cnt_next         = exp_clamped;
          match_count_next = '0;
          hit_next         = '0;
`ifdef STORE_MONITOR_TIMEOUT_EN
          run_cnt_next     = '0;
`endif
          state_next       = (exp_clamped == '0) ? ST_PASS : ST_RUN;
        end
      end
      ST_RUN: begin
        if (memwrite) begin
          // A table hit is checked before the ignore address so entries may use it.
          if (match_any) begin
            match_count_next = match_inc;
            hit_next         = hit_reg | match_mask;
            if (match_inc == cnt_reg) state_next = ST_PASS;
          end else if (dataadr == IGN_ADDR) begin
            if (ignored_count_reg != 16'hFFFF) ignored_count_next = ignored_count_reg + 16'd1;
          end else begin
            state_next     = ST_FAIL;
            fail_code_next = FC_MISMATCH;
            fail_addr_next = dataadr;
            fail_data_next = writedata;
          end
        end
`ifdef STORE_MONITOR_TIMEOUT_EN
        run_cnt_next = run_cnt_reg + 32'd1;
        if (state_next == ST_RUN && run_cnt_next == 32'(TIMEOUT)) begin
          state_next     = ST_FAIL;
          fail_code_next = FC_TIMEOUT;
          fail_addr_next = '0;
          fail_data_next = '0;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= ST_IDLE;
      cnt_reg           <= '0;
      match_count_reg   <= '0;
      ignored_count_reg <= '0;
      hit_reg           <= '0;
      fail_code_reg     <= FC_NONE;
      fail_addr_reg     <= '0;
      fail_data_reg     <= '0;
`ifdef STORE_MONITOR_TIMEOUT_EN
      run_cnt_reg       <= '0;
`endif
    end else begin
      state_reg         <= state_next;
      cnt_reg           <= cnt_next;
      match_count_reg   <= match_count_next;
      ignored_count_reg <= ignored_count_next;
      hit_reg           <= hit_next;
      fail_code_reg     <= fail_code_next;
      fail_addr_reg     <= fail_addr_next;
      fail_data_reg     <= fail_data_next;
`ifdef STORE_MONITOR_TIMEOUT_EN
      run_cnt_reg       <= run_cnt_next;
`endif
    end
  end

  assign pass          = (state_reg == ST_PASS);
  assign fail          = (state_reg == ST_FAIL);
  assign busy          = (state_reg == ST_RUN);
  assign fail_code     = fail_code_reg;
  assign fail_addr     = fail_addr_reg;
  assign fail_data     = fail_data_reg;
  assign match_count   = match_count_reg;
  assign ignored_count = ignored_count_reg;

endmodule
